// File: rtl/cpu.sv
// ----------------------------------------------------------------------------
// cpu: 5-stage in-order MIPS-subset pipeline (IF, ID, EX, MEM, WB).
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous active-high reset; clears PC and pipeline registers
//   start_i - run enable; while low the PC holds and NOPs enter the pipeline
//
// Supported instructions: add, sub, and, or, (mul), addi, lw, sw, beq, j.
// Any other encoding executes as a NOP.
//
// Build option: define CPU_MUL_EN to include the EX-stage 32x32 multiplier
// (R-type funct 011000). Without it, that funct is a NOP with no write.
//
// Memories and the register file are not touched by reset; the environment
// preloads them through the hierarchy (Instruction_Memory.memory,
// Data_Memory.memory, Registers.register).
// ----------------------------------------------------------------------------

package cpu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MUL = 3'd4
    } alu_op_t;
endpackage

// Program counter register.
module cpu_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] next,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_o <= '0;
        else if (enable)
            pc_o <= next;
    end
endmodule

// 256 x 32-bit instruction memory, word-indexed, asynchronous read.
// The load port lets an environment fill the array; cpu ties it off.
module cpu_imem (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  addr,
    output logic [31:0] data
);
    logic [31:0] memory [0:255];

    always_ff @(posedge clk) begin
        if (load_en)
            memory[load_addr] <= load_data;
    end

    assign data = memory[addr];
endmodule

// 32 x 8-bit little-endian data memory. Word accesses wrap inside the
// 32-byte space because the byte offsets are computed in 5 bits.
module cpu_dmem (
    input  logic        clk,
    input  logic        write_en,
    input  logic [4:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);
    logic [7:0] memory [0:31];
    logic [4:0] addr1, addr2, addr3;

    assign addr1 = addr + 5'd1;
    assign addr2 = addr + 5'd2;
    assign addr3 = addr + 5'd3;

    assign read_data = {memory[addr3], memory[addr2], memory[addr1], memory[addr]};

    always_ff @(posedge clk) begin
        if (write_en) begin
            memory[addr]  <= write_data[7:0];
            memory[addr1] <= write_data[15:8];
            memory[addr2] <= write_data[23:16];
            memory[addr3] <= write_data[31:24];
        end
    end
endmodule

// 32 x 32-bit register file. r0 reads as zero and ignores writes.
// A read of the register being written this cycle returns the new value,
// so WB needs no separate forwarding path into ID.
module cpu_regfile (
    input  logic        clk,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_addr_a,
    input  logic [4:0]  read_addr_b,
    output logic [31:0] read_data_a,
    output logic [31:0] read_data_b
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk) begin
        if (write_en && (write_addr != 5'd0))
            register[write_addr] <= write_data;
    end

    always_comb begin
        if (read_addr_a == 5'd0)
            read_data_a = '0;
        else if (write_en && (write_addr == read_addr_a))
            read_data_a = write_data;
        else
            read_data_a = register[read_addr_a];

        if (read_addr_b == 5'd0)
            read_data_b = '0;
        else if (write_en && (write_addr == read_addr_b))
            read_data_b = write_data;
        else
            read_data_b = register[read_addr_b];
    end
endmodule

// Main decoder for the instruction sitting in ID.
module cpu_control
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       Jump_o,
    output logic       Branch_o,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_dst,
    output alu_op_t    alu_op
);
    always_comb begin
        Jump_o     = 1'b0;
        Branch_o   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            6'b000000: begin
                reg_dst = 1'b1;
                case (funct)
                    6'b100000: begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    6'b100010: begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    6'b100100: begin reg_write = 1'b1; alu_op = ALU_AND; end
                    6'b100101: begin reg_write = 1'b1; alu_op = ALU_OR;  end
`ifdef CPU_MUL_EN
                    6'b011000: begin reg_write = 1'b1; alu_op = ALU_MUL; end
`endif
                    default: ;
                endcase
            end
            6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; end
            6'b100011: begin reg_write = 1'b1; mem_to_reg = 1'b1; alu_src = 1'b1; end
            6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; end
            6'b000100: Branch_o = 1'b1;
            6'b000010: Jump_o = 1'b1;
            default: ;
        endcase
    end
endmodule

module cpu
    import cpu_pkg::*;
(
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    // IF stage
    logic [31:0] pc, pc_plus4, pc_next, fetch_instr;
    logic        pc_enable;

    // IF/ID
    logic [31:0] if_id_instr, if_id_pc4;

    // ID stage
    logic [4:0]  id_rs, id_rt, id_rd, id_dest;
    logic [31:0] id_imm, rf_rs, rf_rt, id_rs_fwd, id_rt_fwd;
    logic [31:0] branch_target, jump_target;
    logic        id_jump, id_branch, id_reg_write, id_mem_to_reg, id_mem_write;
    logic        id_alu_src, id_reg_dst, branch_taken;
    alu_op_t     id_alu_op;
    logic        bubble_o, Flush;

    // ID/EX
    logic        id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_write, id_ex_alu_src;
    alu_op_t     id_ex_alu_op;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
    logic [31:0] id_ex_rs_val, id_ex_rt_val, id_ex_imm;

    // EX stage
    logic [31:0] ex_a, ex_b, ex_operand_b, ex_result;
    logic        ex_fwd_ok;

    // EX/MEM
    logic        ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_alu, ex_mem_store;
    logic [31:0] dmem_rdata, ex_mem_value;
    logic        ex_mem_fwd_ok;

    // MEM/WB
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_data;
    logic        mem_wb_fwd_ok;

    // ------------------------------------------------------------------ IF
    cpu_pc PC (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (pc_enable),
        .next   (pc_next),
        .pc_o   (pc)
    );

    cpu_imem Instruction_Memory (
        .clk       (clk_i),
        .load_en   (1'b0),
        .load_addr (8'd0),
        .load_data (32'd0),
        .addr      (pc[9:2]),
        .data      (fetch_instr)
    );

    assign pc_plus4 = pc + 32'd4;

    // A redirect still lands while start_i is low so that a jump already
    // in ID is not lost; only sequential fetch is gated by start_i.
    assign pc_enable = !bubble_o && (Flush || start_i);
    assign pc_next   = Flush ? (id_jump ? jump_target : branch_target) : pc_plus4;

    // IF/ID: holds on a stall, takes a NOP on flush or when not running.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else if (!bubble_o) begin
            if (Flush || !start_i) begin
                if_id_instr <= '0;
                if_id_pc4   <= '0;
            end else begin
                if_id_instr <= fetch_instr;
                if_id_pc4   <= pc_plus4;
            end
        end
    end

    // ------------------------------------------------------------------ ID
    assign id_rs   = if_id_instr[25:21];
    assign id_rt   = if_id_instr[20:16];
    assign id_rd   = if_id_instr[15:11];
    assign id_imm  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign id_dest = id_reg_dst ? id_rd : id_rt;

    cpu_control Control (
        .opcode     (if_id_instr[31:26]),
        .funct      (if_id_instr[5:0]),
        .Jump_o     (id_jump),
        .Branch_o   (id_branch),
        .reg_write  (id_reg_write),
        .mem_to_reg (id_mem_to_reg),
        .mem_write  (id_mem_write),
        .alu_src    (id_alu_src),
        .reg_dst    (id_reg_dst),
        .alu_op     (id_alu_op)
    );

    cpu_regfile Registers (
        .clk         (clk_i),
        .write_en    (mem_wb_reg_write && !rst_i),
        .write_addr  (mem_wb_dest),
        .write_data  (mem_wb_data),
        .read_addr_a (id_rs),
        .read_addr_b (id_rt),
        .read_data_a (rf_rs),
        .read_data_b (rf_rt)
    );

    assign ex_fwd_ok     = id_ex_reg_write && !id_ex_mem_to_reg && (id_ex_dest != 5'd0);
    assign ex_mem_fwd_ok = ex_mem_reg_write && (ex_mem_dest != 5'd0);
    assign mem_wb_fwd_ok = mem_wb_reg_write && (mem_wb_dest != 5'd0);

    // Branch operands for the ID compare. The ALU result still in EX is
    // taken directly so a dependent beq needs no stall; a load in EX is
    // covered by the load-use bubble, after which its data arrives via
    // EX/MEM. WB values come through the register-file bypass.
    always_comb begin
        id_rs_fwd = rf_rs;
        if (ex_fwd_ok && (id_ex_dest == id_rs))
            id_rs_fwd = ex_result;
        else if (ex_mem_fwd_ok && (ex_mem_dest == id_rs))
            id_rs_fwd = ex_mem_value;

        id_rt_fwd = rf_rt;
        if (ex_fwd_ok && (id_ex_dest == id_rt))
            id_rt_fwd = ex_result;
        else if (ex_mem_fwd_ok && (ex_mem_dest == id_rt))
            id_rt_fwd = ex_mem_value;
    end

    assign branch_target = if_id_pc4 + {id_imm[29:0], 2'b00};
    assign jump_target   = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    assign branch_taken  = id_branch && (id_rs_fwd == id_rt_fwd);

    // Load-use stall; it wins over a redirect so the branch re-evaluates
    // once the load data can be forwarded.
    assign bubble_o = id_ex_mem_to_reg && ((id_ex_dest == id_rs) || (id_ex_dest == id_rt));
    assign Flush    = (id_jump || branch_taken) && !bubble_o;

    // ID/EX: a stall inserts a NOP (all controls cleared).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || bubble_o) begin
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_op     <= ALU_ADD;
            id_ex_rs         <= '0;
            id_ex_rt         <= '0;
            id_ex_dest       <= '0;
            id_ex_rs_val     <= '0;
            id_ex_rt_val     <= '0;
            id_ex_imm        <= '0;
        end else begin
            id_ex_reg_write  <= id_reg_write;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_mem_write  <= id_mem_write;
            id_ex_alu_src    <= id_alu_src;
            id_ex_alu_op     <= id_alu_op;
            id_ex_rs         <= id_rs;
            id_ex_rt         <= id_rt;
            id_ex_dest       <= id_dest;
            id_ex_rs_val     <= rf_rs;
            id_ex_rt_val     <= rf_rt;
            id_ex_imm        <= id_imm;
        end
    end

    // ------------------------------------------------------------------ EX
    // Operand forwarding: EX/MEM beats MEM/WB beats the value read in ID.
    always_comb begin
        ex_a = id_ex_rs_val;
        if (ex_mem_fwd_ok && (ex_mem_dest == id_ex_rs))
            ex_a = ex_mem_value;
        else if (mem_wb_fwd_ok && (mem_wb_dest == id_ex_rs))
            ex_a = mem_wb_data;

        ex_b = id_ex_rt_val;
        if (ex_mem_fwd_ok && (ex_mem_dest == id_ex_rt))
            ex_b = ex_mem_value;
        else if (mem_wb_fwd_ok && (mem_wb_dest == id_ex_rt))
            ex_b = mem_wb_data;
    end

    assign ex_operand_b = id_ex_alu_src ? id_ex_imm : ex_b;

    always_comb begin
        case (id_ex_alu_op)
            ALU_ADD: ex_result = ex_a + ex_operand_b;
            ALU_SUB: ex_result = ex_a - ex_operand_b;
            ALU_AND: ex_result = ex_a & ex_operand_b;
            ALU_OR:  ex_result = ex_a | ex_operand_b;
`ifdef CPU_MUL_EN
            ALU_MUL: ex_result = ex_a * ex_operand_b;
`endif
            default: ex_result = ex_a + ex_operand_b;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_dest       <= '0;
            ex_mem_alu        <= '0;
            ex_mem_store      <= '0;
        end else begin
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_to_reg <= id_ex_mem_to_reg;
            ex_mem_mem_write  <= id_ex_mem_write;
            ex_mem_dest       <= id_ex_dest;
            ex_mem_alu        <= ex_result;
            ex_mem_store      <= ex_b;
        end
    end

    // ----------------------------------------------------------------- MEM
    cpu_dmem Data_Memory (
        .clk        (clk_i),
        .write_en   (ex_mem_mem_write && !rst_i),
        .addr       (ex_mem_alu[4:0]),
        .write_data (ex_mem_store),
        .read_data  (dmem_rdata)
    );

    // Value this stage will write back; also the EX/MEM forwarding source.
    assign ex_mem_value = ex_mem_mem_to_reg ? dmem_rdata : ex_mem_alu;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_wb_reg_write <= 1'b0;
            mem_wb_dest      <= '0;
            mem_wb_data      <= '0;
        end else begin
            mem_wb_reg_write <= ex_mem_reg_write;
            mem_wb_dest      <= ex_mem_dest;
            mem_wb_data      <= ex_mem_value;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// ----------------------------------------------------------------------------
// tb_cpu: directed bench for cpu. Single-instruction ALU vectors come from a
// table; forwarding, load-use stall, branch/jump flush, start gating,
// stall-vs-flush priority and mid-run reset use hand-written sequences.
// ----------------------------------------------------------------------------
module tb_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    int checks = 0;
    int failures = 0;

    int bubble_cnt, flush_cnt, both_cnt;
    logic flush_seen, pc_captured;
    logic [31:0] pc_after_flush;

    cpu dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;

    localparam int NUM_VECS = 9;
    vec_t vecs [NUM_VECS];

`ifdef CPU_MUL_EN
    localparam logic [31:0] MUL_TABLE_EXP = 32'h0001_0000;
    localparam logic [31:0] MUL_SCEN_EXP  = 32'd40;
`else
    localparam logic [31:0] MUL_TABLE_EXP = 32'hDEAD_BEEF;
    localparam logic [31:0] MUL_SCEN_EXP  = 32'h0000_0055;
`endif

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] addr);
        return {6'b000010, addr};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Holds reset and wipes memories and registers.
    task automatic clearState();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = 8'h0;
        for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'h0;
        @(negedge clk);
    endtask

    task automatic releaseReset(input logic start_val);
        @(negedge clk);
        rst = 1'b0;
        start = start_val;
        bubble_cnt = 0;
        flush_cnt = 0;
        both_cnt = 0;
        flush_seen = 1'b0;
        pc_captured = 1'b0;
        pc_after_flush = 32'hFFFF_FFFF;
    endtask

    // Runs a fixed number of cycles, sampling on the falling edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (flush_seen && !pc_captured) begin
                pc_after_flush = dut.PC.pc_o;
                pc_captured = 1'b1;
            end
            if (dut.bubble_o) bubble_cnt++;
            if (dut.Flush) begin
                flush_cnt++;
                flush_seen = 1'b1;
            end
            if (dut.bubble_o && dut.Flush) both_cnt++;
        end
    endtask

    initial begin
        vecs[0] = '{"add",        enc_r(5'd1, 5'd2, 5'd3, 6'b100000), 32'd7,         32'd5,         32'd12};
        vecs[1] = '{"sub_neg",    enc_r(5'd1, 5'd2, 5'd3, 6'b100010), 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2] = '{"add_wrap",   enc_r(5'd1, 5'd2, 5'd3, 6'b100000), 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
        vecs[3] = '{"and",        enc_r(5'd1, 5'd2, 5'd3, 6'b100100), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[4] = '{"or",         enc_r(5'd1, 5'd2, 5'd3, 6'b100101), 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[5] = '{"addi_neg",   enc_i(6'b001000, 5'd1, 5'd3, 16'hFFFD), 32'd10,    32'd0,         32'd7};
        vecs[6] = '{"bad_funct",  enc_r(5'd1, 5'd2, 5'd3, 6'b100111), 32'd1,         32'd2,         32'hDEAD_BEEF};
        vecs[7] = '{"bad_opcode", enc_i(6'b001100, 5'd1, 5'd3, 16'h00FF), 32'd1,     32'd2,         32'hDEAD_BEEF};
        vecs[8] = '{"mul_low32",  enc_r(5'd1, 5'd2, 5'd3, 6'b011000), 32'h0001_0000, 32'h0001_0001, MUL_TABLE_EXP};

        // Reset state
        clearState();
        #1;
        checkOutput("reset_pc", dut.PC.pc_o, 32'h0);
        checkOutput("reset_bubble_flush", {30'b0, dut.bubble_o, dut.Flush}, 32'h0);

        // Single-instruction table
        for (int i = 0; i < NUM_VECS; i++) begin
            clearState();
            dut.Registers.register[1] = vecs[i].a;
            dut.Registers.register[2] = vecs[i].b;
            dut.Registers.register[3] = 32'hDEAD_BEEF;
            dut.Instruction_Memory.memory[0] = vecs[i].instr;
            releaseReset(1'b1);
            applyStimulus(8);
            checkOutput(vecs[i].name, dut.Registers.register[3], vecs[i].expected);
        end

        // Back-to-back dependent addi: EX/MEM forwarding, no stall
        clearState();
        dut.Instruction_Memory.memory[0] = enc_i(6'b001000, 5'd0, 5'd8, 16'd5);
        dut.Instruction_Memory.memory[1] = enc_i(6'b001000, 5'd8, 5'd9, 16'd3);
        releaseReset(1'b1);
        applyStimulus(10);
        checkOutput("fwd_r8", dut.Registers.register[8], 32'd5);
        checkOutput("fwd_r9", dut.Registers.register[9], 32'd8);
        checkOutput("fwd_no_bubble", bubble_cnt, 32'd0);

        // Load-use: one bubble, loaded value forwarded
        clearState();
        dut.Data_Memory.memory[0] = 8'h05;
        dut.Instruction_Memory.memory[0] = enc_i(6'b100011, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_r(5'd8, 5'd8, 5'd9, 6'b100000);
        releaseReset(1'b1);
        applyStimulus(10);
        checkOutput("lw_bubbles", bubble_cnt, 32'd1);
        checkOutput("lw_r8", dut.Registers.register[8], 32'd5);
        checkOutput("lw_use_r9", dut.Registers.register[9], 32'd10);

        // Store, little-endian byte order
        clearState();
        dut.Registers.register[9] = 32'h0102_0304;
        dut.Instruction_Memory.memory[0] = enc_i(6'b101011, 5'd0, 5'd9, 16'd4);
        releaseReset(1'b1);
        applyStimulus(8);
        checkOutput("sw_bytes", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                                 dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'h0102_0304);
        checkOutput("sw_neighbours", {dut.Data_Memory.memory[8], dut.Data_Memory.memory[3]}, 32'h0);

        // Taken beq r0,r0,+2: one flush, wrong path squashed, target at word 3
        clearState();
        dut.Instruction_Memory.memory[0] = enc_i(6'b000100, 5'd0, 5'd0, 16'd2);
        dut.Instruction_Memory.memory[1] = enc_i(6'b001000, 5'd0, 5'd10, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'b001000, 5'd0, 5'd11, 16'd2);
        dut.Instruction_Memory.memory[3] = enc_i(6'b001000, 5'd0, 5'd12, 16'd3);
        releaseReset(1'b1);
        applyStimulus(10);
        checkOutput("beq_flushes", flush_cnt, 32'd1);
        checkOutput("beq_target_pc", pc_after_flush, 32'd12);
        checkOutput("beq_wrong_path", dut.Registers.register[10], 32'd0);
        checkOutput("beq_skipped", dut.Registers.register[11], 32'd0);
        checkOutput("beq_target_exec", dut.Registers.register[12], 32'd3);

        // Untaken beq: no flush, fall-through executes
        clearState();
        dut.Registers.register[1] = 32'd1;
        dut.Instruction_Memory.memory[0] = enc_i(6'b000100, 5'd1, 5'd0, 16'd2);
        dut.Instruction_Memory.memory[1] = enc_i(6'b001000, 5'd0, 5'd10, 16'd1);
        releaseReset(1'b1);
        applyStimulus(8);
        checkOutput("beq_untaken_flush", flush_cnt, 32'd0);
        checkOutput("beq_untaken_exec", dut.Registers.register[10], 32'd1);

        // j to word 0x10
        clearState();
        dut.Instruction_Memory.memory[0] = enc_j(26'h10);
        dut.Instruction_Memory.memory[1] = enc_i(6'b001000, 5'd0, 5'd10, 16'd1);
        dut.Instruction_Memory.memory[16] = enc_i(6'b001000, 5'd0, 5'd13, 16'd9);
        releaseReset(1'b1);
        applyStimulus(9);
        checkOutput("j_flushes", flush_cnt, 32'd1);
        checkOutput("j_target_pc", pc_after_flush, 32'h40);
        checkOutput("j_wrong_path", dut.Registers.register[10], 32'd0);
        checkOutput("j_target_exec", dut.Registers.register[13], 32'd9);

        // start_i low: PC holds at 0, nothing executes until started
        clearState();
        dut.Instruction_Memory.memory[0] = enc_i(6'b001000, 5'd0, 5'd14, 16'd1);
        releaseReset(1'b0);
        applyStimulus(6);
        checkOutput("idle_pc", dut.PC.pc_o, 32'h0);
        checkOutput("idle_no_write", dut.Registers.register[14], 32'd0);
        start = 1'b1;
        applyStimulus(8);
        checkOutput("started_exec", dut.Registers.register[14], 32'd1);

        // r0 write discarded; mul 5*8 (or NOP without the multiplier)
        clearState();
        dut.Registers.register[8] = 32'd5;
        dut.Registers.register[9] = 32'd8;
        dut.Registers.register[10] = 32'h55;
        dut.Instruction_Memory.memory[0] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);
        dut.Instruction_Memory.memory[1] = enc_r(5'd8, 5'd9, 5'd10, 6'b011000);
        releaseReset(1'b1);
        applyStimulus(9);
        checkOutput("r0_stays_zero", dut.Registers.register[0], 32'd0);
        checkOutput("mul_r10", dut.Registers.register[10], MUL_SCEN_EXP);

        // Load-use stall on a beq whose raw operands already compare equal:
        // the stall must suppress the flush, which then fires once after it.
        clearState();
        dut.Registers.register[8] = 32'd0;
        dut.Instruction_Memory.memory[0] = enc_i(6'b100011, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_i(6'b000100, 5'd8, 5'd0, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'b001000, 5'd0, 5'd10, 16'd1);
        dut.Instruction_Memory.memory[3] = enc_i(6'b001000, 5'd0, 5'd11, 16'd2);
        releaseReset(1'b1);
        applyStimulus(10);
        checkOutput("prio_bubbles", bubble_cnt, 32'd1);
        checkOutput("prio_flushes", flush_cnt, 32'd1);
        checkOutput("prio_overlap", both_cnt, 32'd0);
        checkOutput("prio_target_pc", pc_after_flush, 32'd12);
        checkOutput("prio_wrong_path", dut.Registers.register[10], 32'd0);
        checkOutput("prio_target_exec", dut.Registers.register[11], 32'd2);

        // Reset mid-run aborts in-flight work
        clearState();
        dut.Instruction_Memory.memory[0] = enc_i(6'b001000, 5'd0, 5'd15, 16'd1);
        dut.Instruction_Memory.memory[1] = enc_j(26'h10);
        releaseReset(1'b1);
        applyStimulus(2);
        checkOutput("midrst_flush_before", {31'b0, dut.Flush}, 32'd1);
        #1;
        rst = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("midrst_pc", dut.PC.pc_o, 32'h0);
        checkOutput("midrst_bubble_flush", {30'b0, dut.bubble_o, dut.Flush}, 32'h0);
        repeat (3) @(negedge clk);
        releaseReset(1'b0);
        applyStimulus(6);
        checkOutput("midrst_no_write", dut.Registers.register[15], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
